// File: rtl/biriscv_decode_queue.sv
// Pre-decode queue between fetch and dual issue: decodes each fetch lane into class
// bits, stores entries in a circular FIFO and presents the two oldest. Optional
// same-cycle bypass of an empty queue is enabled by defining BIRISCV_DECQ_BYPASS_EN.
module biriscv_decode_queue #(
  parameter int FETCH_W = 2,
  parameter int DEPTH   = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 enable_muldiv_i,
  input  logic                 fetch_valid_i,
  input  logic [FETCH_W-1:0]   fetch_mask_i,
  input  logic [32*FETCH_W-1:0] fetch_instr_i,
  input  logic [31:0]          fetch_pc_i,
  input  logic                 fetch_fault_i,
  output logic                 fetch_accept_o,
  output logic                 out0_valid_o,
  output logic [31:0]          out0_instr_o,
  output logic [31:0]          out0_pc_o,
  output logic                 out0_fault_o,
  output logic [7:0]           out0_class_o,
  input  logic                 out0_accept_i,
  output logic                 out1_valid_o,
  output logic [31:0]          out1_instr_o,
  output logic [31:0]          out1_pc_o,
  output logic                 out1_fault_o,
  output logic [7:0]           out1_class_o,
  input  logic                 out1_accept_i
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
    logic [7:0]  cls;
  } entry_t;

  // Class layout {invalid,rd_valid,csr,div,mul,branch,lsu,exec}; anything unrecognised
  // is routed to the CSR unit so it can raise the illegal-instruction trap.
  function automatic logic [7:0] decode_class(input logic [31:0] instr, input logic fault,
                                              input logic muldiv);
    logic [6:0] f7;
    logic [2:0] f3;
    logic exec, lsu, branch, mul, div, csr, rd, inv;
    f7 = instr[31:25];
    f3 = instr[14:12];
    {exec, lsu, branch, mul, div, csr, rd, inv} = '0;
    case (instr[6:0])
      7'b0110111, 7'b0010111: {exec, rd} = 2'b11;
      7'b1101111:             {branch, rd} = 2'b11;
      7'b1100111: if (f3 == 3'b000) {branch, rd} = 2'b11; else inv = 1'b1;
      7'b1100011: if (f3[2:1] != 2'b01) branch = 1'b1; else inv = 1'b1;
      7'b0000011: if (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) {lsu, rd} = 2'b11;
                  else inv = 1'b1;
      7'b0100011: if (f3 inside {3'd0, 3'd1, 3'd2}) lsu = 1'b1; else inv = 1'b1;
      7'b0010011: begin
        if ((f3 == 3'b001 && f7 != 7'b0000000) ||
            (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000)) inv = 1'b1;
        else {exec, rd} = 2'b11;
      end
      7'b0110011: begin
        if (f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)))
          {exec, rd} = 2'b11;
        else if (f7 == 7'b0000001 && muldiv) {mul, div, rd} = {!f3[2], f3[2], 1'b1};
        else inv = 1'b1;
      end
      7'b0001111: if (f3 == 3'b000 || f3 == 3'b001) csr = 1'b1; else inv = 1'b1;
      7'b1110011: begin
        if (f3 == 3'b000) csr = 1'b1;
        else if (f3 != 3'b100) {csr, rd} = 2'b11;
        else inv = 1'b1;
      end
      default: inv = 1'b1;
    endcase
    if (inv) csr = 1'b1;
    if (fault) return 8'hA0;
    return {inv, rd, csr, div, mul, branch, lsu, exec};
  endfunction

  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr, rd_ptr_nxt1;
  logic [CNT_W-1:0]  count, push_cnt, skip, pushes_eff;
  logic [1:0]        pops, stored_pops;
  logic              push_en, bypass;
  entry_t            lane_entry [FETCH_W];
  logic [CNT_W-1:0]  lane_slot [FETCH_W];
  logic [PTR_W-1:0]  wr_idx [FETCH_W];
  entry_t            view0, view1;

  assign fetch_accept_o = !rst_i && !flush_i && ((CNT_W'(DEPTH) - count) >= CNT_W'(FETCH_W));
  assign push_en        = fetch_accept_o && fetch_valid_i;
  assign rd_ptr_nxt1    = rd_ptr + PTR_W'(1);

  // Lanes are compacted: each masked lane lands at the number of masked lanes below it.
  always_comb begin
    push_cnt = '0;
    for (int l = 0; l < FETCH_W; l++) begin
      lane_slot[l]  = push_cnt;
      lane_entry[l] = '{instr: fetch_instr_i[32*l +: 32], pc: fetch_pc_i + 32'(4 * l),
                        fault: fetch_fault_i,
                        cls: decode_class(fetch_instr_i[32*l +: 32], fetch_fault_i,
                                          enable_muldiv_i)};
      wr_idx[l]     = wr_ptr + PTR_W'(lane_slot[l] - skip);
      if (fetch_mask_i[l]) push_cnt = push_cnt + CNT_W'(1);
    end
  end

`ifdef BIRISCV_DECQ_BYPASS_EN
  assign bypass = push_en && (count == '0);

  always_comb begin
    if (bypass) begin
      view0 = '0;
      view1 = '0;
      for (int l = 0; l < FETCH_W; l++) begin
        if (fetch_mask_i[l] && lane_slot[l] == CNT_W'(0)) view0 = lane_entry[l];
        if (fetch_mask_i[l] && lane_slot[l] == CNT_W'(1)) view1 = lane_entry[l];
      end
      out0_valid_o = push_cnt >= CNT_W'(1);
      out1_valid_o = push_cnt >= CNT_W'(2);
    end else begin
      view0 = mem[rd_ptr];
      view1 = mem[rd_ptr_nxt1];
      out0_valid_o = !rst_i && count >= CNT_W'(1);
      out1_valid_o = !rst_i && count >= CNT_W'(2);
    end
  end
`else
  assign bypass       = 1'b0;
  assign view0        = mem[rd_ptr];
  assign view1        = mem[rd_ptr_nxt1];
  assign out0_valid_o = !rst_i && count >= CNT_W'(1);
  assign out1_valid_o = !rst_i && count >= CNT_W'(2);
`endif

  assign {out0_instr_o, out0_pc_o, out0_fault_o, out0_class_o} = view0;
  assign {out1_instr_o, out1_pc_o, out1_fault_o, out1_class_o} = view1;

  // Bypassed lanes taken by issue are never written; pops then come out of the packet.
  assign pops        = (out0_accept_i && out0_valid_o) ?
                       (2'd1 + {1'b0, out1_accept_i && out1_valid_o}) : 2'd0;
  assign skip        = bypass ? CNT_W'(pops) : '0;
  assign stored_pops = bypass ? 2'd0 : pops;
  assign pushes_eff  = push_en ? (push_cnt - skip) : '0;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of its sources, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PTR_W'(stored_pops);
      wr_ptr <= wr_ptr + PTR_W'(pushes_eff);
      count  <= count + pushes_eff - CNT_W'(stored_pops);
    end
  end

  // NOTE: payload storage is deliberately not reset; count gates every read, so
  // stale contents are never observed and the array maps onto plain RAM/flops.
  always_ff @(posedge clk_i) begin
    for (int l = 0; l < FETCH_W; l++) begin
      if (push_en && fetch_mask_i[l] && lane_slot[l] >= skip) mem[wr_idx[l]] <= lane_entry[l];
    end
  end

endmodule

// File: tb/tb_biriscv_decode_queue.sv
// Randomised bench for biriscv_decode_queue against a queue-based reference model
// with a pre-classified instruction table; directed scenarios precede the random run.
module tb_biriscv_decode_queue;
  localparam int FETCH_W = 2;
  localparam int DEPTH   = 8;
  localparam int NTPL    = 16;
`ifdef BIRISCV_DECQ_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // Instruction templates: fixed encoding, randomisable field mask, class with RV32M
  // disabled and enabled.
  localparam logic [31:0] T_BASE [NTPL] = '{
    32'h00000013, 32'h00000037, 32'h00002003, 32'h00002023,
    32'h00000063, 32'h0000006F, 32'h00000033, 32'h40000033,
    32'h02000033, 32'h02004033, 32'h00001073, 32'h00000073,
    32'h0000000F, 32'h0000007F, 32'h40001013, 32'h00002063};
  localparam logic [31:0] T_RND [NTPL] = '{
    32'hFFFF8F80, 32'hFFFFFF80, 32'hFFFF8F80, 32'hFFFF8F80,
    32'hFFFF8F80, 32'hFFFFFF80, 32'h01FF8F80, 32'h01FF8F80,
    32'h01FF8F80, 32'h01FF8F80, 32'hFFFF8F80, 32'h00000000,
    32'hFFFF8F80, 32'hFFFFFF80, 32'h01FF8F80, 32'hFFFF8F80};
  localparam logic [7:0] T_OFF [NTPL] = '{
    8'h41, 8'h41, 8'h42, 8'h02, 8'h04, 8'h44, 8'h41, 8'h41,
    8'hA0, 8'hA0, 8'h60, 8'h20, 8'h20, 8'hA0, 8'hA0, 8'hA0};
  localparam logic [7:0] T_ON [NTPL] = '{
    8'h41, 8'h41, 8'h42, 8'h02, 8'h04, 8'h44, 8'h41, 8'h41,
    8'h48, 8'h50, 8'h60, 8'h20, 8'h20, 8'hA0, 8'hA0, 8'hA0};

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
    logic [7:0]  cls;
  } entry_t;

  logic clk = 1'b0;
  logic rst_i, flush_i, enable_muldiv_i, fetch_valid_i, fetch_fault_i;
  logic [FETCH_W-1:0]    fetch_mask_i;
  logic [32*FETCH_W-1:0] fetch_instr_i;
  logic [31:0]           fetch_pc_i;
  logic                  fetch_accept_o;
  logic                  out0_valid_o, out0_fault_o, out0_accept_i;
  logic                  out1_valid_o, out1_fault_o, out1_accept_i;
  logic [31:0]           out0_instr_o, out0_pc_o, out1_instr_o, out1_pc_o;
  logic [7:0]            out0_class_o, out1_class_o;

  logic [7:0] lane_cls_off [FETCH_W];
  logic [7:0] lane_cls_on  [FETCH_W];
  entry_t     model_q [$];
  int         checks_total  = 0;
  int         checks_passed = 0;

  always #5 clk = ~clk;

  biriscv_decode_queue #(.FETCH_W(FETCH_W), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .enable_muldiv_i(enable_muldiv_i),
    .fetch_valid_i(fetch_valid_i), .fetch_mask_i(fetch_mask_i),
    .fetch_instr_i(fetch_instr_i), .fetch_pc_i(fetch_pc_i), .fetch_fault_i(fetch_fault_i),
    .fetch_accept_o(fetch_accept_o),
    .out0_valid_o(out0_valid_o), .out0_instr_o(out0_instr_o), .out0_pc_o(out0_pc_o),
    .out0_fault_o(out0_fault_o), .out0_class_o(out0_class_o), .out0_accept_i(out0_accept_i),
    .out1_valid_o(out1_valid_o), .out1_instr_o(out1_instr_o), .out1_pc_o(out1_pc_o),
    .out1_fault_o(out1_fault_o), .out1_class_o(out1_class_o), .out1_accept_i(out1_accept_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic set_lane(input int l, input logic [31:0] instr, input logic [7:0] c_off,
                          input logic [7:0] c_on);
    fetch_instr_i[32*l +: 32] = instr;
    lane_cls_off[l] = c_off;
    lane_cls_on[l]  = c_on;
  endtask

  task automatic set_random_lane(input int l);
    int t;
    t = $urandom_range(NTPL - 1);
    set_lane(l, (T_BASE[t] & ~T_RND[t]) | ($urandom() & T_RND[t]), T_OFF[t], T_ON[t]);
  endtask

  task automatic idle_inputs();
    {rst_i, flush_i, fetch_valid_i, fetch_fault_i, out0_accept_i, out1_accept_i} = '0;
    fetch_mask_i = '0;
  endtask

  // Compare DUT outputs at the falling edge, then move the model across the next edge.
  task automatic sample();
    entry_t lanes [$];
    entry_t view  [$];
    entry_t e;
    bit     exp_accept, byp, v0, v1;
    int     pops;
    @(negedge clk);
    exp_accept = !rst_i && !flush_i && (DEPTH - model_q.size() >= FETCH_W);
    for (int l = 0; l < FETCH_W; l++) begin
      if (fetch_mask_i[l]) begin
        e.instr = fetch_instr_i[32*l +: 32];
        e.pc    = fetch_pc_i + 4 * l;
        e.fault = fetch_fault_i;
        e.cls   = fetch_fault_i ? 8'hA0 : (enable_muldiv_i ? lane_cls_on[l] : lane_cls_off[l]);
        lanes.push_back(e);
      end
    end
    byp = BYPASS && fetch_valid_i && exp_accept && model_q.size() == 0;
    if (byp) view = lanes;
    else view = model_q;
    v0 = !rst_i && view.size() >= 1;
    v1 = !rst_i && view.size() >= 2;
    check("fetch_accept", fetch_accept_o, exp_accept);
    check("out0_valid", out0_valid_o, v0);
    check("out1_valid", out1_valid_o, v1);
    if (v0) begin
      check("out0_instr", out0_instr_o, view[0].instr);
      check("out0_pc", out0_pc_o, view[0].pc);
      check("out0_fault", out0_fault_o, view[0].fault);
      check("out0_class", out0_class_o, view[0].cls);
    end
    if (v1) begin
      check("out1_instr", out1_instr_o, view[1].instr);
      check("out1_pc", out1_pc_o, view[1].pc);
      check("out1_fault", out1_fault_o, view[1].fault);
      check("out1_class", out1_class_o, view[1].cls);
    end
    pops = (out0_accept_i && v0) ? 1 + int'(out1_accept_i && v1) : 0;
    if (rst_i || flush_i) model_q.delete();
    else if (byp) begin
      repeat (pops) void'(lanes.pop_front());
      model_q = lanes;
    end else begin
      repeat (pops) void'(model_q.pop_front());
      if (fetch_valid_i && exp_accept) foreach (lanes[i]) model_q.push_back(lanes[i]);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic do_flush();
    idle_inputs();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
  endtask

  initial begin
    idle_inputs();
    enable_muldiv_i = 1'b0;
    fetch_pc_i      = '0;
    fetch_instr_i   = '0;
    for (int l = 0; l < FETCH_W; l++) begin
      lane_cls_off[l] = 8'hA0;
      lane_cls_on[l]  = 8'hA0;
    end
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tick();
    rst_i = 1'b0;

    // ADDI + LW packet
    fetch_valid_i = 1'b1;
    fetch_mask_i  = 2'b11;
    fetch_pc_i    = 32'h8000_0000;
    set_lane(0, 32'h00100093, 8'h41, 8'h41);
    set_lane(1, 32'h0000a103, 8'h42, 8'h42);
    tick();
    idle_inputs();
    sample();
    check("t1_out0_pc", out0_pc_o, 32'h8000_0000);
    check("t1_out0_class", out0_class_o, 8'h41);
    check("t1_out1_pc", out1_pc_o, 32'h8000_0004);
    check("t1_out1_class", out1_class_o, 8'h42);
    advance();

    // Upper lane only, MUL with RV32M off then on
    for (int m = 0; m < 2; m++) begin
      do_flush();
      enable_muldiv_i = m[0];
      fetch_valid_i   = 1'b1;
      fetch_mask_i    = 2'b10;
      fetch_pc_i      = 32'h0000_2000;
      set_lane(1, 32'h02208033, 8'hA0, 8'h48);
      tick();
      idle_inputs();
      sample();
      check("t2_out1_valid", out1_valid_o, 1'b0);
      check("t2_out0_pc", out0_pc_o, 32'h0000_2004);
      check("t2_out0_class", out0_class_o, m == 0 ? 8'hA0 : 8'h48);
      advance();
    end

    // Fill to capacity without issue
    do_flush();
    for (int k = 0; k < 4; k++) begin
      fetch_valid_i = 1'b1;
      fetch_mask_i  = 2'b11;
      fetch_pc_i    = 32'h0000_3000 + 8 * k;
      set_random_lane(0);
      set_random_lane(1);
      sample();
      check("t3_fill_accept", fetch_accept_o, 1'b1);
      advance();
    end
    idle_inputs();
    sample();
    check("t3_full_accept", fetch_accept_o, 1'b0);
    advance();
    out0_accept_i = 1'b1;
    out1_accept_i = 1'b1;
    sample();
    check("t3_pop_same_cycle", fetch_accept_o, 1'b0);
    advance();
    idle_inputs();
    sample();
    check("t3_pop_next_cycle", fetch_accept_o, 1'b1);
    advance();

    // Streaming with both outputs consumed every cycle: pointers wrap repeatedly
    do_flush();
    for (int k = 0; k < 20; k++) begin
      fetch_valid_i = 1'b1;
      fetch_mask_i  = 2'b11;
      fetch_pc_i    = 32'h0001_0000 + 8 * k;
      out0_accept_i = 1'b1;
      out1_accept_i = 1'b1;
      set_random_lane(0);
      set_random_lane(1);
      tick();
    end
    idle_inputs();
    out0_accept_i = 1'b1;
    out1_accept_i = 1'b1;
    repeat (2) tick();

    // Flush beats concurrent push and pop at count 5
    do_flush();
    fetch_valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      fetch_mask_i = (k == 2) ? 2'b01 : 2'b11;
      fetch_pc_i   = 32'h0002_0000 + 8 * k;
      set_random_lane(0);
      set_random_lane(1);
      tick();
    end
    flush_i       = 1'b1;
    fetch_mask_i  = 2'b11;
    out0_accept_i = 1'b1;
    out1_accept_i = 1'b1;
    tick();
    idle_inputs();
    sample();
    check("t5_flush_out0_valid", out0_valid_o, 1'b0);
    check("t5_flush_out1_valid", out1_valid_o, 1'b0);
    advance();
    fetch_valid_i = 1'b1;
    fetch_mask_i  = 2'b11;
    fetch_pc_i    = 32'h0002_1000;
    tick();
    idle_inputs();
    out1_accept_i = 1'b1;
    tick();
    sample();
    check("t5_out1_only_no_pop", out0_pc_o, 32'h0002_1000);
    check("t5_out1_only_valid", out1_valid_o, 1'b1);
    advance();

    // Empty queue, packet consumed by issue in the same cycle
    do_flush();
    fetch_valid_i = 1'b1;
    fetch_mask_i  = 2'b11;
    fetch_pc_i    = 32'h0003_0000;
    out0_accept_i = 1'b1;
    out1_accept_i = 1'b1;
    sample();
`ifdef BIRISCV_DECQ_BYPASS_EN
    check("t6_same_cycle_valid", out0_valid_o, 1'b1);
    check("t6_same_cycle_pc", out0_pc_o, 32'h0003_0000);
`else
    check("t6_same_cycle_valid", out0_valid_o, 1'b0);
`endif
    advance();
    idle_inputs();
    sample();
`ifdef BIRISCV_DECQ_BYPASS_EN
    check("t6_next_cycle_valid", out0_valid_o, 1'b0);
`else
    check("t6_next_cycle_valid", out0_valid_o, 1'b1);
`endif
    advance();

    // Random traffic
    for (int c = 0; c < 800; c++) begin
      rst_i           = ($urandom_range(63) == 0);
      flush_i         = ($urandom_range(19) == 0);
      enable_muldiv_i = $urandom_range(1);
      fetch_valid_i   = ($urandom_range(9) < 7);
      fetch_mask_i    = FETCH_W'($urandom());
      fetch_fault_i   = ($urandom_range(9) == 0);
      fetch_pc_i      = $urandom() & 32'hFFFF_FFFC;
      out0_accept_i   = $urandom_range(1);
      out1_accept_i   = $urandom_range(1);
      for (int l = 0; l < FETCH_W; l++) set_random_lane(l);
      tick();
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
